// File: rtl/biset_master.sv
// BiSet bus master: one valid/ready register request -> single-cycle BiSet beat -> registered reply.
// Optional write readback check enabled by defining BISET_MASTER_RDBACK_EN.

package BiSet;
    typedef struct packed {
        logic        en;
        logic        we;
        logic [31:0] addr;
    } biSetCtrl;

    typedef logic [31:0] biSetData;
    typedef logic [31:0] biSetReply;

    function automatic biSetCtrl BiSetCtrlIdle();
        return '0;
    endfunction

    function automatic biSetCtrl BiSetCtrl(input logic [31:0] addr, input logic we);
        biSetCtrl c;
        c.en   = 1'b1;
        c.we   = we;
        c.addr = addr;
        return c;
    endfunction
endpackage

module biset_master #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [31:0]       rsp_rdata_o,
    output logic              rsp_err_o,
    output logic [CNT_W-1:0]  txn_cnt_o,
    output BiSet::biSetCtrl   setCtrl_o,
    output BiSet::biSetData   setWrite_o,
    input  BiSet::biSetReply  setReply_i
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        RESP
    } state_t;

    state_t state_q, state_d;
    logic   accept;
    logic   rsp_hs;

    assign req_ready_o = (state_q == IDLE);
    assign rsp_valid_o = (state_q == RESP);
    assign accept      = (state_q == IDLE) && req_valid_i;
    assign rsp_hs      = (state_q == RESP) && rsp_ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid_i) state_d = ISSUE;
            ISSUE:   state_d = CAPTURE;
            CAPTURE: state_d = RESP;
            RESP:    if (rsp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The bus beat is registered at accept, so it is live exactly during ISSUE.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            setCtrl_o   <= BiSet::BiSetCtrlIdle();
            setWrite_o  <= '0;
            rsp_rdata_o <= '0;
            txn_cnt_o   <= '0;
        end else begin
            setCtrl_o <= accept ? BiSet::BiSetCtrl(32'(req_addr_i), req_we_i)
                                : BiSet::BiSetCtrlIdle();
            if (accept) begin
                setWrite_o <= req_wdata_i;
            end
            if (state_q == CAPTURE) begin
                rsp_rdata_o <= setReply_i;
            end
            if (rsp_hs) begin
                txn_cnt_o <= txn_cnt_o + CNT_W'(1);
            end
        end
    end

`ifdef BISET_MASTER_RDBACK_EN
    logic we_q;
    logic err_q;
    logic err_seen;
    logic mismatch;

    assign mismatch  = we_q && (setReply_i != setWrite_o);
    assign rsp_err_o = err_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            err_seen <= 1'b0;
        end else begin
            if (accept) begin
                we_q <= req_we_i;
            end
            if (state_q == CAPTURE) begin
                err_q <= mismatch;
                if (mismatch) begin
                    err_seen <= 1'b1;
                end
            end else if (rsp_hs) begin
                err_q <= 1'b0;
            end
        end
    end
`else
    assign rsp_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_biset_master.sv
// Randomized scoreboard bench for biset_master with behavioural BiSet slaves (32/8/16-bit)
// and a register-map reference model.

module tb_biset_master;
    localparam int CNT_W = 2;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b0;
    logic              req_valid_i = 1'b0;
    logic              req_ready_o;
    logic              req_we_i = 1'b0;
    logic [7:0]        req_addr_i = '0;
    logic [31:0]       req_wdata_i = '0;
    logic              rsp_valid_o;
    logic              rsp_ready_i = 1'b0;
    logic [31:0]       rsp_rdata_o;
    logic              rsp_err_o;
    logic [CNT_W-1:0]  txn_cnt_o;
    BiSet::biSetCtrl   setCtrl_o;
    BiSet::biSetData   setWrite_o;
    BiSet::biSetReply  setReply_i;

    biset_master #(.ADDR_W(8), .CNT_W(CNT_W)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_we_i    (req_we_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o),
        .txn_cnt_o   (txn_cnt_o),
        .setCtrl_o   (setCtrl_o),
        .setWrite_o  (setWrite_o),
        .setReply_i  (setReply_i)
    );

    always #5 clk_i = ~clk_i;

    int unsigned cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Slave fabric: not reset by rst_i, replies registered, unselected slaves drive 0.
    logic [31:0] r3 = '0;
    logic [7:0]  r5 = '0;
    logic [15:0] r9 = '0;
    logic [31:0] rep3 = '0, rep5 = '0, rep9 = '0;

    always @(posedge clk_i) begin
        rep3 <= '0;
        rep5 <= '0;
        rep9 <= '0;
        if (setCtrl_o.en) begin
            if (setCtrl_o.addr == 32'd3) begin
                if (setCtrl_o.we) r3 <= setWrite_o;
                rep3 <= setCtrl_o.we ? setWrite_o : r3;
            end
            if (setCtrl_o.addr == 32'd5) begin
                if (setCtrl_o.we) r5 <= setWrite_o[7:0];
                rep5 <= {24'b0, (setCtrl_o.we ? setWrite_o[7:0] : r5)};
            end
            if (setCtrl_o.addr == 32'd9) begin
                if (setCtrl_o.we) r9 <= setWrite_o[15:0];
                rep9 <= {16'b0, (setCtrl_o.we ? setWrite_o[15:0] : r9)};
            end
        end
    end
    assign setReply_i = rep3 | rep5 | rep9;

    // Reference model: register map as an array, width given by a mask per address.
    logic [31:0] model_mem [0:255];
    initial for (int i = 0; i < 256; i++) model_mem[i] = '0;

    function automatic logic [31:0] mask_of(input logic [7:0] a);
        case (a)
            8'd3:    return 32'hFFFF_FFFF;
            8'd5:    return 32'h0000_00FF;
            8'd9:    return 32'h0000_FFFF;
            default: return 32'h0;
        endcase
    endfunction

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int unsigned acc;
    } exp_t;

    exp_t        q[$];
    exp_t        cur;
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned done = 0;
    int unsigned beats = 0;
    int unsigned rsp_idx = 0;
    int unsigned wait_left = 0;
    bit          in_resp = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: bus beats and responses, checked against the queued expectations.
    always @(negedge clk_i) begin
        if (rst_i) begin
            in_resp     = 0;
            beats       = 0;
            done        = 0;
            rsp_ready_i = 1'b0;
        end else begin
            if (setCtrl_o.en) begin
                beats++;
                if (q.size() > 0) begin
                    chk("beat_addr", setCtrl_o.addr, {24'b0, q[0].addr});
                    chk("beat_we", 32'(setCtrl_o.we), 32'(q[0].we));
                    if (q[0].we) chk("beat_wdata", setWrite_o, q[0].wdata);
                end else begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_beat actual=beat expected=idle (t=%0t)", $time);
                end
            end
            if (rsp_valid_o) begin
                chk("req_ready_busy", 32'(req_ready_o), 32'd0);
                if (!in_resp) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_rsp actual=valid expected=none (t=%0t)", $time);
                    end else begin
                        cur = q.pop_front();
                        chk("latency", cyc, cur.acc + 3);
                        chk("rdata", rsp_rdata_o, cur.rdata);
                        chk("err", 32'(rsp_err_o), 32'(cur.err));
                        chk("txn_cnt", 32'(txn_cnt_o), done % (1 << CNT_W));
                        chk("issue_beats", beats, 1);
                        beats     = 0;
                        in_resp   = 1;
                        wait_left = (rsp_idx == 3) ? 10 : $urandom_range(0, 2);
                        rsp_idx++;
                    end
                end else begin
                    chk("rdata_stable", rsp_rdata_o, cur.rdata);
                    chk("err_stable", 32'(rsp_err_o), 32'(cur.err));
                end
                if (in_resp) begin
                    if (wait_left > 0) begin
                        rsp_ready_i = 1'b0;
                        wait_left--;
                    end else begin
                        rsp_ready_i = 1'b1;
                        in_resp     = 0;
                        done++;
                    end
                end
            end else begin
                rsp_ready_i = 1'($urandom_range(0, 1));
            end
        end
    end

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic send(input logic we, input logic [7:0] a, input logic [31:0] d);
        int unsigned n = 0;
        exp_t e;
        req_valid_i = 1'b1;
        req_we_i    = we;
        req_addr_i  = a;
        req_wdata_i = d;
        while (!req_ready_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        if (!req_ready_o) begin
            checks++;
            errors++;
            $display("FAIL req_ready_timeout actual=0 expected=1 (t=%0t)", $time);
        end else begin
            if (we) model_mem[a] = d & mask_of(a);
            e.we    = we;
            e.addr  = a;
            e.wdata = d;
            e.rdata = model_mem[a];
`ifdef BISET_MASTER_RDBACK_EN
            e.err   = we && (e.rdata != d);
`else
            e.err   = 1'b0;
`endif
            e.acc   = cyc;
            q.push_back(e);
        end
        @(negedge clk_i);
        req_valid_i = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready_o), 32'd1);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid_o), 32'd0);
        chk({tag, "_rdata"}, rsp_rdata_o, 32'd0);
        chk({tag, "_err"}, 32'(rsp_err_o), 32'd0);
        chk({tag, "_cnt"}, 32'(txn_cnt_o), 32'd0);
        chk({tag, "_ctrl_en"}, 32'(setCtrl_o.en), 32'd0);
        chk({tag, "_ctrl_we"}, 32'(setCtrl_o.we), 32'd0);
        chk({tag, "_ctrl_addr"}, setCtrl_o.addr, 32'd0);
        chk({tag, "_wdata"}, setWrite_o, 32'd0);
    endtask

    task automatic drain();
        int unsigned n = 0;
        while ((q.size() != 0 || in_resp) && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        chk("drain_queue", q.size(), 0);
        @(negedge clk_i);
    endtask

    logic [7:0] addr_pool [0:4];

    initial begin
        addr_pool[0] = 8'd3;
        addr_pool[1] = 8'd5;
        addr_pool[2] = 8'd9;
        addr_pool[3] = 8'h7F;
        addr_pool[4] = 8'd3;

        #3 rst_i = 1'b1;
        #1 check_reset("t1");
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);

        send(1'b1, 8'd3, 32'h0000_00A5);
        send(1'b0, 8'd3, 32'h0);
        send(1'b0, 8'h7F, 32'h0);
        send(1'b1, 8'd5, 32'h0000_01FF);
        send(1'b0, 8'd5, 32'h0);
        send(1'b1, 8'd9, 32'hCAFE_1234);
        send(1'b0, 8'd9, 32'h0);

        for (int i = 0; i < 40; i++) begin
            logic [7:0] a;
            a = ($urandom_range(0, 7) == 0) ? 8'($urandom) : addr_pool[$urandom_range(0, 4)];
            send(1'($urandom_range(0, 1)), a, $urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk_i);
        end
        drain();

        // Reset while the write is in CAPTURE: response dropped, slave keeps the data.
        send(1'b1, 8'd3, 32'hDEAD_BEEF);
        @(negedge clk_i);
        q.delete();
        rst_i = 1'b1;
        #1 check_reset("rst_capture");
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("no_rsp_after_rst", 32'(rsp_valid_o), 32'd0);
        end
        send(1'b0, 8'd3, 32'h0);
        send(1'b0, 8'd5, 32'h0);
        drain();
        chk("slave_retained", r3, 32'hDEAD_BEEF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
